// File: rtl/seq_sub64_pkg.sv
// Shared constants, index-width helper and FSM state type for the sliced subtractor.
package seq_sub64_pkg;

    localparam int SUB_WIDTH  = 64;
    localparam int SUB_SLICE  = 8;
    localparam int SUB_NSLICE = SUB_WIDTH / SUB_SLICE;

    // Index width that never collapses to zero when only one slice exists.
    function automatic int idx_w(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

    localparam int SUB_IDX_W = idx_w(SUB_NSLICE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_sub64_slice.sv
// One slice of the subtractor: d = a + ~b + c_in, with c_out the carry (inverse borrow).
module sub8_slice
    import seq_sub64_pkg::*;
#(
    parameter int W = SUB_SLICE
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic [W-1:0] d,
    output logic         c_out
);

    logic [W:0] sum;

    assign sum   = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, c_in};
    assign d     = sum[W-1:0];
    assign c_out = sum[W];

endmodule

// File: rtl/seq_sub64.sv
// Multi-cycle subtractor: one SLICE-bit slice per RUN cycle through a single shared slice unit.
module seq_sub64
    import seq_sub64_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH,
    parameter int SLICE = SUB_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             zero,
    output logic             ovf
);

    localparam int NS  = WIDTH / SLICE;
    localparam int IW  = idx_w(NS);
    localparam int MSB = WIDTH - 1;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic             b_out_q, b_out_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [SLICE-1:0] sl_a, sl_b, sl_d;
    logic             sl_c;
    logic             last;

    assign last = (idx_q == IW'(NS - 1));
    assign sl_a = a_q[int'(idx_q) * SLICE +: SLICE];
    assign sl_b = b_q[int'(idx_q) * SLICE +: SLICE];

    sub8_slice #(.W(SLICE)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry_q),
        .d     (sl_d),
        .c_out (sl_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last)      state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state; outputs are only rewritten in RUN, so they hold through DONE.
    always_comb begin
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        b_out_d = b_out_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = ~b_in;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                diff_d[int'(idx_q) * SLICE +: SLICE] = sl_d;
                carry_d = sl_c;
                idx_d   = last ? '0 : idx_q + IW'(1);
                if (last) begin
                    b_out_d = ~sl_c;
                    zero_d  = (diff_d == '0);
                    ovf_d   = (a_q[MSB] != b_q[MSB]) && (diff_d[MSB] != a_q[MSB]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            b_out_q <= b_out_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        diff      = diff_q;
        b_out     = b_out_q;
        zero      = zero_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_seq_sub64.sv
// Scoreboard bench for seq_sub64: driver pushes model results on accept, monitor pops on handshake.
`timescale 1ns/1ps
module tb_seq_sub64;

    localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [65:0] SMIN = -66'sh0_8000_0000_0000_0000;

    typedef struct {
        logic [63:0] a, b, diff;
        logic        bin, bout, zero, ovf;
        longint      acc;
    } exp_t;

    logic        clk = 1'b0, rst, in_valid, in_ready, b_in, out_valid, out_ready;
    logic        b_out, zero, ovf;
    logic [63:0] a, b, diff;

    exp_t   exp_q[$];
    int     n_vec = 0, n_err = 0, n_sent = 0, n_recv = 0;
    longint cyc = 0;
    bit     rand_ready = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_sub64 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .b_out(b_out), .zero(zero), .ovf(ovf)
    );

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain wide unsigned and signed arithmetic.
    function automatic exp_t model(input logic [63:0] x, input logic [63:0] y, input logic bi);
        exp_t e;
        logic [64:0] w;
        logic signed [65:0] sx, sy, sb, s;
        w  = {1'b0, x} - {1'b0, y} - {64'd0, bi};
        sx = {{2{x[63]}}, x};
        sy = {{2{y[63]}}, y};
        sb = {65'd0, bi};
        s  = sx - sy - sb;
        e.a    = x;
        e.b    = y;
        e.bin  = bi;
        e.diff = w[63:0];
        e.bout = ({1'b0, x} < ({1'b0, y} + {64'd0, bi}));
        e.zero = (w[63:0] == 64'd0);
        e.ovf  = (s > SMAX) || (s < SMIN);
        e.acc  = 0;
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the accept edge.
    task automatic send(input logic [63:0] x, input logic [63:0] y, input logic bi, input bit push);
        exp_t e;
        int t = 0;
        in_valid = 1'b1; a = x; b = y; b_in = bi;
        do begin
            @(negedge clk);
            t++;
        end while (!in_ready && t < 100);
        if (!in_ready) begin
            n_vec++; n_err++;
            $display("FAIL accept_timeout: in_ready stayed %b, required 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e = model(x, y, bi);
            e.acc = cyc + 1;
            exp_q.push_back(e);
            n_sent++;
            $display("send #%0d a=%h b=%h b_in=%b exp diff=%h", n_sent, x, y, bi, e.diff);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; b_in = 1'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk64("drain_pending", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Monitor: checks latency, hold-stability, in_ready while busy, and popped results.
    initial begin
        exp_t e;
        logic [63:0] h_diff;
        logic h_bo, h_z, h_o;
        bit prev_v = 0, prev_hs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 0; prev_hs = 0;
                continue;
            end
            if (prev_hs) begin
                chk1("valid_drop_after_hs", out_valid, 1'b0);
                chk1("ready_after_hs", in_ready, 1'b1);
            end
            if (out_valid) begin
                chk1("in_ready_busy", in_ready, 1'b0);
                if (!prev_v) begin
                    if (exp_q.size() == 0) begin
                        n_vec++; n_err++;
                        $display("FAIL spurious_result: got out_valid=1 diff=%h, required no result", diff);
                    end else begin
                        chk64("latency", 64'(cyc - exp_q[0].acc), 64'd8);
                    end
                end else begin
                    chk64("hold_diff", diff, h_diff);
                    chk1("hold_b_out", b_out, h_bo);
                    chk1("hold_zero", zero, h_z);
                    chk1("hold_ovf", ovf, h_o);
                end
                h_diff = diff; h_bo = b_out; h_z = zero; h_o = ovf;
                if (out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_recv++;
                    $display("recv #%0d a=%h b=%h b_in=%b diff=%h b_out=%b zero=%b ovf=%b",
                             n_recv, e.a, e.b, e.bin, diff, b_out, zero, ovf);
                    chk64("diff", diff, e.diff);
                    chk1("b_out", b_out, e.bout);
                    chk1("zero", zero, e.zero);
                    chk1("ovf", ovf, e.ovf);
                end
            end
            prev_v  = out_valid;
            prev_hs = out_valid && out_ready;
        end
    end

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 99) < 70);
        end
    end

    initial begin
        logic [63:0] x, y;
        int t;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; b_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk64("rst_diff", diff, 64'd0);
        chk1("rst_b_out", b_out, 1'b0);
        chk1("rst_zero", zero, 1'b0);
        chk1("rst_ovf", ovf, 1'b0);
        @(posedge clk); #1 rst = 1'b0;

        send(64'h5, 64'h3, 1'b0, 1);
        send(64'h0, 64'h1, 1'b0, 1);
        send(64'h1, 64'h0, 1'b1, 1);
        send(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1);
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1);
        send(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1);
        drain();

        // Consumer stall with noisy inputs.
        out_ready = 1'b0;
        send(64'hDEAD_BEEF_0000_0001, 64'h0000_0001_FFFF_FFFF, 1'b1, 1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 20);
        chk1("stall_out_valid", out_valid, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            in_valid = 1'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom}; b_in = 1'($urandom);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        chk1("idle_after_release", in_ready, 1'b1);
        chk64("no_extra_accept", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;

        // Reset while slice 4 of an operation is in flight.
        send('1, 64'h1, 1'b0, 0);
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk1("midrst_out_valid", out_valid, 1'b0);
        chk1("midrst_in_ready", in_ready, 1'b1);
        chk64("midrst_diff", diff, 64'd0);
        chk1("midrst_b_out", b_out, 1'b0);
        chk1("midrst_zero", zero, 1'b0);
        chk1("midrst_ovf", ovf, 1'b0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        send(64'h10, 64'h10, 1'b0, 1);
        drain();

        // Random back-to-back traffic with random stalls.
        rand_ready = 1;
        for (int i = 0; i < 2500; i++) begin
            x = pick();
            y = ($urandom_range(0, 4) == 0) ? x : pick();
            send(x, y, 1'($urandom), 1);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rand_ready = 0;
        out_ready = 1'b1;
        drain();
        chk64("sent_vs_recv", 64'(n_recv), 64'(n_sent));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
